series_job_dispatcher: RTL and testbench

Job dispatcher and result collector that sits directly upstream of the series-evaluation `Circuit`, whose ports are `start`, `x`, `y`, `ready` and `Rout`. It queues operand pairs arriving on a valid/ready stream in a small FIFO. It launches each pair on the core with a single-cycle `start` pulse and waits for the core's `ready`. It then presents the captured 17-bit `Rout` on a valid/ready result stream, in strict arrival order.

---
 rtl/series_job_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_series_job_dispatcher.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/series_job_dispatcher.sv
// Operand FIFO + launch/collect FSM in front of the series-evaluation core.
// Optional watchdog on the core wait: define DISPATCH_TIMEOUT_EN.
module series_job_dispatcher #(
  parameter int DEPTH = 4,
  parameter int XW    = 17,
  parameter int YW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XW-1:0]              in_x,
  input  logic [YW-1:0]              in_y,
  output logic                       core_start,
  output logic [XW-1:0]              core_x,
  output logic [YW-1:0]              core_y,
  input  logic                       core_ready,
  input  logic [XW-1:0]              core_rout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XW-1:0]              out_data,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XW-1:0]   core_x_q, core_x_d;
  logic [YW-1:0]   core_y_q, core_y_d;
  logic            out_valid_q, out_valid_d;
  logic [XW-1:0]   out_data_q, out_data_d;
  logic [XW-1:0]   mem_x_q [DEPTH];
  logic [YW-1:0]   mem_y_q [DEPTH];
  logic            push;
  logic            pop;

`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0]      wdog_q, wdog_d;
  logic            timeout_q, timeout_d;
`endif

  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign core_start = (state_q == S_LAUNCH);
  assign core_x     = core_x_q;
  assign core_y     = core_y_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign count      = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef DISPATCH_TIMEOUT_EN
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_ARM;
      // core_ready may still reflect the previous job here
      S_ARM: begin
        state_d = S_WAIT;
`ifdef DISPATCH_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (core_ready) begin
          out_data_d  = core_rout;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (wdog_q == 8'hff) begin
          out_data_d  = XW'(17'h10000);
          out_valid_d = 1'b1;
          timeout_d   = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    core_x_d = core_x_q;
    core_y_d = core_y_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d   = rptr_q + 1'b1;
      core_x_d = mem_x_q[rptr_q];
      core_y_d = mem_y_q[rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x_q[wptr_q] <= in_x;
      mem_y_q[wptr_q] <= in_y;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      core_x_q    <= '0;
      core_y_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_series_job_dispatcher.sv
// Bench for series_job_dispatcher with a behavioural core and result scoreboard.
// Set DISPATCH_TIMEOUT_EN to match the RTL build when exercising the watchdog.
module tb_series_job_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_x;
  logic [7:0]  in_y;
  logic        core_start;
  logic [16:0] core_x;
  logic [7:0]  core_y;
  logic        c_ready;
  logic [16:0] c_rout;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        busy;
  logic [2:0]  count;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int c_delay = 5;
  int c_cnt;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  series_job_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .core_start (core_start),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_ready (c_ready),
    .core_rout  (c_rout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .count      (count),
    .timeout    (timeout)
  );

  // core model: mode 0 -> 0x180, mode 1 -> {0,y}, mode 2 -> never ready
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_ready <= 1'b1;
      c_cnt   <= 0;
      c_rout  <= '0;
    end else if (core_start) begin
      c_ready <= 1'b0;
      c_cnt   <= c_delay;
      c_rout  <= (mode == 0) ? 17'h00180 : {9'b0, core_y};
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1 && mode != 2) c_ready <= 1'b1;
    end
  end

  function automatic logic [16:0] exp_for(input logic [7:0] y);
    if (mode == 0) return 17'h00180;
    if (mode == 1) return {9'b0, y};
    return 17'h10000;
  endfunction

  task automatic push_job(input logic [16:0] x, input logic [7:0] y);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_accept in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(exp_for(y));
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      n++;
      @(negedge clk);
    end
    ok = out_valid;
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({count, in_ready, core_start, core_x, core_y} !== {3'd0, 1'b1, 1'b0, 17'd0, 8'd0}) begin
      bad++;
      $display("FAIL reset_in cnt=%0d rdy=%b st=%b x=%h y=%h want 0 1 0 0 0",
               count, in_ready, core_start, core_x, core_y);
    end
    total++;
    if ({out_valid, out_data, busy, timeout} !== {1'b0, 17'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_out v=%b d=%h busy=%b to=%b want 0 0 0 0",
               out_valid, out_data, busy, timeout);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    logic [16:0] e;
    mode = 0;
    push_job(17'h00002, 8'h08);
    @(negedge clk);
    total++;
    if (core_start !== 1'b0) begin
      bad++;
      $display("FAIL start_early core_start=%b want 0", core_start);
    end
    @(negedge clk);
    total++;
    if ({core_start, core_x, core_y} !== {1'b1, 17'h00002, 8'h08}) begin
      bad++;
      $display("FAIL launch st=%b x=%h y=%h want 1 00002 08", core_start, core_x, core_y);
    end
    @(negedge clk);
    total++;
    if (core_start !== 1'b0) begin
      bad++;
      $display("FAIL start_pulse core_start=%b want 0", core_start);
    end
    wait_valid(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || out_data !== e) begin
      bad++;
      $display("FAIL single_result v=%b d=%h want 1 %h", out_valid, out_data, e);
    end
    handshake();
    @(negedge clk);
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_idle v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_full();
    bit ok;
    bit stall;
    logic [16:0] e;
    mode = 1;
    out_ready = 1'b0;
    push_job(17'h00100, 8'h01);
    wait_valid(ok);
    for (int i = 0; i < 4; i++) begin
      push_job(17'h00101 + 17'(i), 8'(i + 2));
    end
    @(negedge clk);
    total++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL full cnt=%0d rdy=%b want 4 0", count, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x = 17'h00105;
    in_y = 8'h06;
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || count !== 3'd4) stall = 1'b0;
    end
    total++;
    if (!stall) begin
      bad++;
      $display("FAIL stall rdy=%b cnt=%0d want 0 4", in_ready, count);
    end
    e = exp_q.pop_front();
    total++;
    if (!ok || out_data !== e) begin
      bad++;
      $display("FAIL full_first v=%b d=%h want 1 %h", out_valid, out_data, e);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({count, in_ready} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL pop_free cnt=%0d rdy=%b want 3 1", count, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(exp_for(8'h06));
    @(negedge clk);
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL fifth_accept cnt=%0d want 4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || out_data !== e) begin
        bad++;
        $display("FAIL drain%0d v=%b d=%h want 1 %h", i, out_valid, out_data, e);
      end
      @(posedge clk);
    end
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    logic [16:0] e;
    mode = 0;
    out_ready = 1'b0;
    push_job(17'h1abcd, 8'h33);
    wait_valid(ok);
    e = exp_q.pop_front();
    stable = ok;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== e || core_start !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL backpressure d=%h st=%b v=%b want %h 0 1", out_data, core_start, out_valid, e);
    end
    handshake();
  endtask

  task automatic test_order();
    bit ok;
    bit low;
    logic [16:0] e;
    logic [7:0] ys [3];
    ys[0] = 8'h08;
    ys[1] = 8'h10;
    ys[2] = 8'h20;
    mode = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_job(17'h00040 + 17'(i), ys[i]);
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || out_data !== e) begin
        bad++;
        $display("FAIL order%0d v=%b d=%h want 1 %h", i, out_valid, out_data, e);
      end
      @(posedge clk);
      if (i < 2) begin
        low = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (out_valid !== 1'b0) low = 1'b0;
        end
        total++;
        if (!low) begin
          bad++;
          $display("FAIL b2b_gap%0d out_valid=%b want 0", i, out_valid);
        end
      end
    end
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 1;
    c_delay = 30;
    out_ready = 1'b0;
    push_job(17'h00011, 8'h11);
    push_job(17'h00022, 8'h22);
    push_job(17'h00033, 8'h33);
    repeat (3) @(negedge clk);
    total++;
    if ({count, busy, core_x} !== {3'd2, 1'b1, 17'h00011}) begin
      bad++;
      $display("FAIL pre_reset cnt=%0d busy=%b x=%h want 2 1 00011", count, busy, core_x);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({count, in_ready, core_start, core_x, core_y} !== {3'd0, 1'b1, 1'b0, 17'd0, 8'd0}) begin
      bad++;
      $display("FAIL async_in cnt=%0d rdy=%b st=%b x=%h y=%h want 0 1 0 0 0",
               count, in_ready, core_start, core_x, core_y);
    end
    total++;
    if ({out_valid, out_data, busy, timeout} !== {1'b0, 17'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_out v=%b d=%h busy=%b to=%b want 0 0 0 0",
               out_valid, out_data, busy, timeout);
    end
    exp_q.delete();
    c_delay = 5;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_timeout();
    bit ok;
    logic [16:0] e;
    mode = 2;
    out_ready = 1'b0;
    push_job(17'h00003, 8'h07);
`ifdef DISPATCH_TIMEOUT_EN
    wait_valid(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || out_data !== e || timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout v=%b d=%h to=%b want 1 %h 1", out_valid, out_data, timeout, e);
    end
    handshake();
    @(negedge clk);
    total++;
    if ({out_valid, timeout} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_clear v=%b to=%b want 0 0", out_valid, timeout);
    end
`else
    ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || timeout !== 1'b0) ok = 1'b0;
    end
    e = 17'h0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL no_timeout v=%b to=%b d=%h want 0 0 %h", out_valid, timeout, out_data, e);
    end
`endif
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mode = 0;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_backpressure();
    test_order();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
